// File: rtl/arbitrated_multiplexer_if.sv
// Handshake bundle between N producers, the arbitrated multiplexer and one consumer.
// The master modport is the producer/consumer side; the slave modport is the multiplexer.
interface arbitrated_multiplexer_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SELW     = 2
);
  logic                      mode;
  logic [SELW-1:0]           address;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_channel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output mode, address, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_channel, out_valid
  );

  modport slave (
    input  mode, address, in_data, in_valid, out_ready,
    output in_ready, out_data, out_channel, out_valid
  );
endinterface

// File: rtl/arbitrated_multiplexer.sv
// Registered N-channel multiplexer: fixed address selection or round-robin arbitration,
// with valid/ready handshaking on every input and on the single output register.
module arbitrated_multiplexer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SELW     = 2
) (
  input logic                     clk,
  input logic                     reset,
  arbitrated_multiplexer_if.slave bus
);
  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_channel_q, out_channel_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  logic                load_en_s;
  logic                found_s;
  logic                grant_s;
  logic [SELW-1:0]     sel_s;
  logic                hi_found_s, lo_found_s;
  logic [SELW-1:0]     hi_sel_s, lo_sel_s;
  logic [WIDTH-1:0]    sel_data_s;
  logic [CHANNELS-1:0] in_ready_s;

  // Channel selection; round-robin splits channels at ptr and prefers the upper part,
  // the descending loop leaving the lowest valid index of each part as the winner.
  always_comb begin
    sel_s      = '0;
    found_s    = 1'b0;
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_sel_s   = '0;
    lo_sel_s   = '0;
    if (bus.mode == 1'b0) begin
      sel_s = bus.address;
      for (int c = 0; c < CHANNELS; c++) begin
        if ((bus.address == SELW'(c)) && bus.in_valid[c]) begin
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (bus.in_valid[c] && (SELW'(c) >= ptr_q)) begin
          hi_found_s = 1'b1;
          hi_sel_s   = SELW'(c);
        end else if (bus.in_valid[c]) begin
          lo_found_s = 1'b1;
          lo_sel_s   = SELW'(c);
        end else begin
          hi_found_s = hi_found_s;
        end
      end
      found_s = hi_found_s | lo_found_s;
      sel_s   = hi_found_s ? hi_sel_s : lo_sel_s;
    end
  end

  assign load_en_s = !out_valid_q || bus.out_ready;
  assign grant_s   = !reset && load_en_s && found_s;

  // Data steering and the one-hot accept vector.
  always_comb begin
    sel_data_s = '0;
    in_ready_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_s == SELW'(c)) begin
        sel_data_s    = bus.in_data[c*WIDTH +: WIDTH];
        in_ready_s[c] = grant_s;
      end else begin
        in_ready_s[c] = 1'b0;
      end
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    ptr_d         = ptr_q;
    if (grant_s) begin
      out_data_d    = sel_data_s;
      out_channel_d = sel_s;
      out_valid_d   = 1'b1;
      if (bus.mode == 1'b1) begin
        ptr_d = (sel_s == LAST_CH) ? '0 : sel_s + SELW'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (load_en_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      ptr_q         <= '0;
    end else begin
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      ptr_q         <= ptr_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Directed and random stimulus for arbitrated_multiplexer, compared against a
// cycle-level behavioural model of the selection, handshake and pointer rules.
module tb_arbitrated_multiplexer;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  arbitrated_multiplexer_if #(.CHANNELS(CH), .WIDTH(W), .SELW(SW)) bus ();

  arbitrated_multiplexer #(.CHANNELS(CH), .WIDTH(W), .SELW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which channel the rules pick this cycle, and whether it is granted.
  function automatic void predict(output bit g, output int s);
    bit load;
    bit found;
    load  = !m_valid || bus.out_ready;
    found = 1'b0;
    g = 1'b0;
    s = 0;
    if (reset) return;
    if (!bus.mode) begin
      s = int'(bus.address);
      found = (s < CH) && bus.in_valid[s];
    end else begin
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (m_ptr + k) % CH;
        if (!found && bus.in_valid[c]) begin
          found = 1'b1;
          s = c;
        end
      end
    end
    g = load && found;
  endfunction

  // One clock cycle: check accepts before the edge, advance model, check outputs after.
  task automatic step(input string tag);
    bit g;
    int s;
    #1;
    predict(g, s);
    check({tag, ":in_ready"}, bus.in_ready, g ? (32'd1 << s) : 32'd0);
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = 0;
    end else if (g) begin
      m_data  = bus.in_data[s*W +: W];
      m_chan  = s;
      m_valid = 1'b1;
      if (bus.mode) m_ptr = (s + 1) % CH;
    end else if (!m_valid || bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, ":out_valid"},   bus.out_valid,   32'(m_valid));
    check({tag, ":out_data"},    bus.out_data,    32'(m_data));
    check({tag, ":out_channel"}, bus.out_channel, 32'(m_chan));
  endtask

  initial begin
    int rr_exp[6];
    int wrap_exp[6];
    rr_exp   = '{0, 1, 2, 3, 0, 1};
    wrap_exp = '{0, 3, 0, 3, 3, 3};
    m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = 0;

    // Reset for two cycles with every input valid
    reset = 1'b1;
    bus.mode = 1'b0;
    bus.address = 2'd0;
    bus.in_valid = 4'b1111;
    bus.in_data = 32'h33221100;
    bus.out_ready = 1'b1;
    step("reset0");
    check("reset_ready", bus.in_ready, 32'd0);
    step("reset1");
    check("reset_out_valid", bus.out_valid, 32'd0);
    reset = 1'b0;

    // Fixed mode, stepping the address
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      step("fixed");
      check("fixed_word", bus.out_data, 32'(a * 17));
      check("fixed_chan", bus.out_channel, 32'(a));
    end
    bus.address = 2'd2;
    bus.in_valid = 4'b1011;
    step("fixed_novalid");
    check("fixed_novalid_ov", bus.out_valid, 32'd0);

    // Round-robin, all channels valid
    bus.mode = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step("rr_all");
      check("rr_seq", bus.out_channel, 32'(rr_exp[i]));
    end

    // Round-robin wrap between channels 3 and 0
    reset = 1'b1;
    step("wrap_reset");
    reset = 1'b0;
    bus.in_valid = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.in_valid = 4'b1000;
      step("rr_wrap");
      check("rr_wrap_seq", bus.out_channel, 32'(wrap_exp[i]));
    end

    // Backpressure holding 8'h22
    bus.mode = 1'b0;
    bus.address = 2'd2;
    bus.in_valid = 4'b0100;
    bus.in_data = 32'h33221100;
    step("bp_load");
    check("bp_load_word", bus.out_data, 32'h22);
    bus.out_ready = 1'b0;
    bus.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = $urandom;
      bus.in_valid = 4'($urandom);
      step("bp_hold");
      check("bp_hold_word", bus.out_data, 32'h22);
      check("bp_hold_valid", bus.out_valid, 32'd1);
    end
    bus.out_ready = 1'b1;
    bus.mode = 1'b0;
    bus.address = 2'd0;
    bus.in_valid = 4'b0001;
    bus.in_data = 32'h000000AA;
    step("bp_release");
    check("bp_release_word", bus.out_data, 32'hAA);

    // Reset mid-stream with ptr at 2 and a held word
    bus.mode = 1'b1;
    bus.in_valid = 4'b0010;
    step("mid_grant1");
    bus.out_ready = 1'b0;
    step("mid_hold");
    reset = 1'b1;
    step("mid_reset");
    check("mid_reset_ov", bus.out_valid, 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1111;
    step("mid_after");
    check("mid_after_chan", bus.out_channel, 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.mode = 1'($urandom);
      bus.address = 2'($urandom);
      bus.in_valid = 4'($urandom);
      bus.in_data = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
